// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, FSM state type and zero-register address for the register file
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO = 0;
  typedef enum logic {CLEAR, READY} rf_state_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with reserve-over-writeback priority and clear-all
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int REG_CNT  = 32,
  parameter int RD_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_all,
  input  logic                       set_en,
  input  logic [ADDR_W-1:0]          set_addr,
  input  logic                       clr_en,
  input  logic [ADDR_W-1:0]          clr_addr,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [RD_PORTS-1:0]        rd_pend
);
  logic [REG_CNT-1:0] pend;
  // the later set assignment overrides a same-cycle clear to the same bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= '0;
    else if (clr_all) pend <= '0;
    else begin
      if (clr_en) pend[clr_addr] <= 1'b0;
      if (set_en) pend[set_addr] <= 1'b1;
    end
  for (genvar k = 0; k < RD_PORTS; k++) begin : g_tap
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_pend[k] = int'(a) < REG_CNT ? pend[a] : 1'b0;
  end
endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: RD_PORTS registered reads, one write, hardware clear sweep, pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to reads of the written address.
module multiport_register_file import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int REG_CNT  = 32,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       Clk_In,
  input  logic                       Reset_n_In,
  input  logic                       Clear_Req_In,
  output logic                       Ready_Out,
  input  logic [RD_PORTS*ADDR_W-1:0] Rd_Addr_In,
  output logic [RD_PORTS*DATA_W-1:0] Rd_Data_Out,
  output logic [RD_PORTS-1:0]        Rd_Pend_Out,
  input  logic                       Wr_En_In,
  input  logic [ADDR_W-1:0]          Wr_Addr_In,
  input  logic [DATA_W-1:0]          Wr_Data_In,
  input  logic                       Resv_En_In,
  input  logic [ADDR_W-1:0]          Resv_Addr_In
);
  rf_state_e state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [DATA_W-1:0] mem [REG_CNT];
  logic ready, clr_all, wr_ok, resv_ok;
  logic [RD_PORTS-1:0] sb_pend, rd_pend_nx;
  logic [RD_PORTS*DATA_W-1:0] rd_data_nx;
  assign ready = state == READY;
  assign Ready_Out = ready;
  assign clr_all = ready && Clear_Req_In;
  assign wr_ok = ready && Wr_En_In && int'(Wr_Addr_In) < REG_CNT &&
                 !(ZERO_REG == 1 && int'(Wr_Addr_In) == REG_ZERO);
  assign resv_ok = ready && Resv_En_In && int'(Resv_Addr_In) < REG_CNT &&
                   !(ZERO_REG == 1 && int'(Resv_Addr_In) == REG_ZERO);
  always_ff @(posedge Clk_In or negedge Reset_n_In)
    if (!Reset_n_In) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (ready) begin
      state_nx = Clear_Req_In ? CLEAR : READY;
      idx_nx   = '0;
    end else begin
      state_nx = int'(idx) == REG_CNT - 1 ? READY : CLEAR;
      idx_nx   = int'(idx) == REG_CNT - 1 ? '0 : idx + 1'b1;
    end
  end
  // no reset on the array: the sweep zeroes it, which keeps it RAM-inferable
  always_ff @(posedge Clk_In)
    if (!ready) mem[idx] <= '0;
    else if (wr_ok) mem[Wr_Addr_In] <= Wr_Data_In;
  regfile_scoreboard #(.ADDR_W(ADDR_W), .REG_CNT(REG_CNT), .RD_PORTS(RD_PORTS)) u_sb (
    .clk      (Clk_In),
    .rst_n    (Reset_n_In),
    .clr_all  (clr_all),
    .set_en   (resv_ok),
    .set_addr (Resv_Addr_In),
    .clr_en   (wr_ok),
    .clr_addr (Wr_Addr_In),
    .rd_addr  (Rd_Addr_In),
    .rd_pend  (sb_pend)
  );
  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic in_rng, is_zero, byp;
    assign a = Rd_Addr_In[k*ADDR_W +: ADDR_W];
    assign in_rng = int'(a) < REG_CNT;
    assign is_zero = ZERO_REG == 1 && int'(a) == REG_ZERO;
`ifdef REGFILE_BYPASS_EN
    assign byp = wr_ok && a == Wr_Addr_In;
`else
    assign byp = 1'b0;
`endif
    assign rd_data_nx[k*DATA_W +: DATA_W] = !ready || !in_rng || is_zero ? '0 :
                                            byp ? Wr_Data_In : mem[a];
    assign rd_pend_nx[k] = !ready || !in_rng || is_zero ? 1'b0 :
                           byp ? resv_ok && Resv_Addr_In == a : sb_pend[k];
  end
  always_ff @(posedge Clk_In or negedge Reset_n_In)
    if (!Reset_n_In) begin
      Rd_Data_Out <= '0;
      Rd_Pend_Out <= '0;
    end else begin
      Rd_Data_Out <= rd_data_nx;
      Rd_Pend_Out <= rd_pend_nx;
    end
endmodule
